vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Arbitrates one single-port synchronous framebuffer RAM between VGA scan-out and a pixel writer.
//  Scan-out always wins. Scan-out is driven by the VGA timing block's pixel counters and supplies the VGA data input.
//  The framebuffer is downscaled by 2^SCALE_SHIFT: default 160x120 x 3-bit RGB.
//  The writer (draw engine/CPU) gets the RAM only in the slack between display fetches.
// PARAMETERS
//  H_RES        640  visible pixels per line
//  V_RES        480  visible lines
//  SCALE_SHIFT  2    log2 of the screen-to-framebuffer scale; must be >=2
//  ADDR_W       15   RAM address width; must hold FB_W*FB_H-1
//  Derived: FB_W = H_RES>>SCALE_SHIFT, FB_H = V_RES>>SCALE_SHIFT
// PORTS
//  clk        in   1       system clock (2x the pixel clock)
//  rst        in   1       asynchronous, active-low reset
//  pix_x      in   19      current horizontal pixel counter
//  pix_y      in   19      current line counter
//  pix_active in   1       1 = visible area
//  pix_data   out  3       RGB to VGA data input
//  wr_req     in   1       writer request; hold until wr_ack
//  wr_addr    in   ADDR_W  writer RAM address
//  wr_data    in   3       writer RGB
//  wr_ack     out  1       1-cycle pulse: write committed
//  mem_addr   out  ADDR_W  RAM address (registered)
//  mem_we     out  1       RAM write enable (registered)
//  mem_wdata  out  3       RAM write data (registered)
//  mem_rdata  in   3       RAM read data; valid 1 clk after mem_addr
//  underrun   out  1       sticky: display address changed while a display read was in flight
// BEHAVIOUR
//  Reset: state=IDLE. pix_data, wr_ack, mem_addr, mem_we, mem_wdata and underrun all 0. last-fetch valid cleared.
//  fb_addr = (pix_y>>SCALE_SHIFT)*FB_W + (pix_x>>SCALE_SHIFT), computed in ADDR_W bits.
//  in_fb = pix_active && (pix_x>>S)<FB_W && (pix_y>>S)<FB_H.
//  disp_pending = in_fb && (!last_valid || fb_addr!=last_addr).
//  !in_fb: pix_data<=0 next edge; last_valid<=0; no fetch.
//  FSM (one decision per edge in IDLE; priority display > clear > writer):
//   IDLE: if disp_pending -> mem_addr<=fb_addr, mem_we<=0, last_addr<=fb_addr, last_valid<=1 -> RD.
//         elif writer eligible & wr_req -> mem_addr<=wr_addr, mem_wdata<=wr_data, mem_we<=1, wr_ack<=1 -> WR.
//   RD:   RAM samples the address -> CAP.
//   CAP:  pix_data<=mem_rdata -> IDLE.
//   WR:   mem_we<=0, wr_ack<=0 -> IDLE. wr_req is ignored in this cycle (no double grant).
//  Latency: display issue to pix_data update = 2 edges; IDLE write decision to RAM commit = 1 edge.
//  Worst-case display delay behind a write = 1 extra edge. Fits, since fb_addr changes every >=8 clk.
//  underrun set if fb_addr changes while state is RD or CAP and in_fb. Cleared only by reset.
//  pix_data holds its value between fetches. mem_we is never high in RD or CAP.
//  Reset mid-write: the in-flight write is abandoned; mem_we drops asynchronously with reset.
// CONFIGURATION
//  FB_CLEAR_EN defined: adds ports clr_req (in, 1), clr_color (in, 3), clr_busy (out, 1; reset 0).
//   clr_req=1 sets clr_busy=1 and clr_ptr=0; a new clr_req while busy restarts from 0.
//   While clr_busy: IDLE without disp_pending writes clr_color at clr_ptr via WR (wr_ack not pulsed), then clr_ptr++.
//   Writer is not eligible while clr_busy.
//   After the write to FB_W*FB_H-1, clr_busy<=0 at the WR->IDLE edge.
//  FB_CLEAR_EN undefined: the clear ports and logic are absent; the writer is always eligible.
// TESTING
//  1 Reset: rst=0 with wr_req=1 -> all outputs 0, no mem_we. Release: first write acked within 2 clk.
//  2 Display fetch: pix_active=1, pix_x=8, pix_y=4 -> mem_addr=162, mem_we=0. Edge+2: pix_data = RAM[162].
//    Holding x in 8..11 causes no refetch.
//  3 Write: pix_active=0, wr_req, wr_addr=100, wr_data=3'b101 -> next edge wr_ack=1 with mem_we=1, mem_addr=100.
//    Then wr_ack=0. Later fetch of addr 100 returns 3'b101.
//  4 Collision: disp_pending and wr_req in the same cycle -> read issued first, wr_ack 3 edges later.
//    Full-frame scan with random writes: underrun stays 0.
//  5 Boundaries: pix_x=640 or pix_y=480 with pix_active=1 -> pix_data=0, no fetch.
//    pix_x=639, pix_y=479 -> mem_addr=19199.
//  6 FB_CLEAR_EN: clr_req with clr_color=3'b010, pix_active=0 -> 19200 writes, addresses 0..19199.
//    clr_busy falls after the last write. wr_req pending meanwhile is acked only after clr_busy=0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous framebuffer RAM between
// VGA scan-out (highest priority) and a pixel writer that uses the idle slots
// between display fetches. The framebuffer is the screen downscaled by
// 2^SCALE_SHIFT in each direction (default 160x120, 3-bit RGB).
//
// Optional feature: define FB_CLEAR_EN to add a background framebuffer clear
// engine (clr_req_i / clr_color_i / clr_busy_o). Without it the writer is
// always eligible for free RAM slots.
//
// Handshake: wr_req_i is a level request that the writer holds, together with
// stable wr_addr_i / wr_data_i, until it sees the single-cycle wr_ack_o pulse.
// wr_ack_o rises on the same edge that drives mem_we_o, and the RAM commits
// the write on the following edge. A request seen while the acked write is
// still being committed is ignored, so one request never gets two grants.
//
// Debug: state_o exposes the arbiter FSM (0 IDLE, 1 RD, 2 CAP, 3 WR).
module vga_fb_arbiter #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [18:0]       pix_x_i,
  input  logic [18:0]       pix_y_i,
  input  logic              pix_active_i,
  output logic [2:0]        pix_data_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [2:0]        wr_data_i,
  output logic              wr_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [2:0]        mem_wdata_o,
  input  logic [2:0]        mem_rdata_i,
  output logic              underrun_o,
`ifdef FB_CLEAR_EN
  input  logic              clr_req_i,
  input  logic [2:0]        clr_color_i,
  output logic              clr_busy_o,
`endif
  output logic [1:0]        state_o
);

  localparam int FB_W    = H_RES >> SCALE_SHIFT;
  localparam int FB_H    = V_RES >> SCALE_SHIFT;
  localparam int FB_SIZE = FB_W * FB_H;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_CAP  = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  // Registered state
  logic [1:0]        state_q,     state_d;
  logic [2:0]        pix_data_q,  pix_data_d;
  logic              wr_ack_q,    wr_ack_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_we_q,    mem_we_d;
  logic [2:0]        mem_wdata_q, mem_wdata_d;
  logic              underrun_q,  underrun_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              last_valid_q, last_valid_d;

`ifdef FB_CLEAR_EN
  logic              clr_busy_q,  clr_busy_d;
  logic [ADDR_W-1:0] clr_ptr_q,   clr_ptr_d;
  logic              clr_last_q,  clr_last_d;
`endif

  // Screen-to-framebuffer coordinate mapping
  logic [18:0]       fb_x;
  logic [18:0]       fb_y;
  logic [ADDR_W-1:0] fb_addr;
  logic              in_fb;
  logic              disp_pending;
  logic              addr_moved;
  logic              in_read;
  logic              wr_eligible;
  logic              clear_go;

  assign fb_x    = pix_x_i >> SCALE_SHIFT;
  assign fb_y    = pix_y_i >> SCALE_SHIFT;
  assign in_fb   = pix_active_i && (fb_x < 19'(FB_W)) && (fb_y < 19'(FB_H));
  assign fb_addr = ADDR_W'(fb_y) * ADDR_W'(FB_W) + ADDR_W'(fb_x);

  // A fetch is needed whenever the visible framebuffer cell differs from the
  // one last fetched (or nothing valid was fetched since leaving the area).
  assign addr_moved   = in_fb && (fb_addr != last_addr_q);
  assign disp_pending = in_fb && (!last_valid_q || (fb_addr != last_addr_q));
  assign in_read      = (state_q == ST_RD) || (state_q == ST_CAP);

`ifdef FB_CLEAR_EN
  assign wr_eligible = !clr_busy_q;
  assign clear_go    = clr_busy_q;
`else
  assign wr_eligible = 1'b1;
  assign clear_go    = 1'b0;
`endif

  // Next-state logic: one arbitration decision per edge in IDLE
  always_comb begin
    state_d      = state_q;
    pix_data_d   = pix_data_q;
    wr_ack_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    underrun_d   = underrun_q;
    last_addr_d  = last_addr_q;
    last_valid_d = last_valid_q;
`ifdef FB_CLEAR_EN
    clr_busy_d   = clr_busy_q;
    clr_ptr_d    = clr_ptr_q;
    clr_last_d   = clr_last_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (disp_pending) begin
          mem_addr_d   = fb_addr;
          last_addr_d  = fb_addr;
          last_valid_d = 1'b1;
          state_d      = ST_RD;
        end else if (clear_go) begin
`ifdef FB_CLEAR_EN
          mem_addr_d  = clr_ptr_q;
          mem_wdata_d = clr_color_i;
          mem_we_d    = 1'b1;
          clr_ptr_d   = clr_ptr_q + 1'b1;
          clr_last_d  = (clr_ptr_q == ADDR_W'(FB_SIZE - 1));
          state_d     = ST_WR;
`endif
        end else if (wr_eligible && wr_req_i) begin
          mem_addr_d  = wr_addr_i;
          mem_wdata_d = wr_data_i;
          mem_we_d    = 1'b1;
          wr_ack_d    = 1'b1;
          state_d     = ST_WR;
        end
      end
      ST_RD: begin
        // RAM samples mem_addr on this edge; data is ready one edge later.
        state_d = ST_CAP;
      end
      ST_CAP: begin
        pix_data_d = mem_rdata_i;
        state_d    = ST_IDLE;
      end
      ST_WR: begin
        // The write commits on this edge; the request line is not looked at.
        state_d = ST_IDLE;
`ifdef FB_CLEAR_EN
        if (clr_last_q) begin
          clr_busy_d = 1'b0;
          clr_last_d = 1'b0;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Outside the framebuffer area the output is blanked and the fetch
    // history forgotten, so re-entry always refetches.
    if (!in_fb) begin
      pix_data_d   = 3'd0;
      last_valid_d = 1'b0;
    end

    // The display cell moved before the previous fetch was delivered.
    if (in_read && addr_moved) begin
      underrun_d = 1'b1;
    end

`ifdef FB_CLEAR_EN
    // A clear request (re)starts the sweep from address 0.
    if (clr_req_i) begin
      clr_busy_d = 1'b1;
      clr_ptr_d  = '0;
      clr_last_d = 1'b0;
    end
`endif
  end

  // State registers; reset also drops mem_we immediately, abandoning a write
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      pix_data_q   <= 3'd0;
      wr_ack_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 3'd0;
      underrun_q   <= 1'b0;
      last_addr_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_data_q   <= pix_data_d;
      wr_ack_q     <= wr_ack_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      underrun_q   <= underrun_d;
      last_addr_q  <= last_addr_d;
      last_valid_q <= last_valid_d;
    end
  end

`ifdef FB_CLEAR_EN
  // Clear engine registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clr_busy_q <= 1'b0;
      clr_ptr_q  <= '0;
      clr_last_q <= 1'b0;
    end else begin
      clr_busy_q <= clr_busy_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_last_q <= clr_last_d;
    end
  end

  assign clr_busy_o = clr_busy_q;
`endif

  assign pix_data_o  = pix_data_q;
  assign wr_ack_o    = wr_ack_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wdata_o = mem_wdata_q;
  assign underrun_o  = underrun_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed and randomized bench for vga_fb_arbiter with a
// behavioural RAM, a framebuffer image model and a write scoreboard.
// Build with FB_CLEAR_EN defined to also exercise the clear engine.
module tb_vga_fb_arbiter;

  localparam int ADDR_W  = 15;
  localparam int FB_W    = 160;
  localparam int FB_SIZE = 19200;
  localparam int SCALE   = 4;

  logic              clk;
  logic              rst_n;
  logic [18:0]       pix_x;
  logic [18:0]       pix_y;
  logic              pix_active;
  logic [2:0]        pix_data;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [2:0]        mem_wdata;
  logic [2:0]        mem_rdata;
  logic              underrun;
  logic [1:0]        state;
`ifdef FB_CLEAR_EN
  logic              clr_req;
  logic [2:0]        clr_color;
  logic              clr_busy;
`endif

  int checks   = 0;
  int failures = 0;

  vga_fb_arbiter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .pix_x_i      (pix_x),
    .pix_y_i      (pix_y),
    .pix_active_i (pix_active),
    .pix_data_o   (pix_data),
    .wr_req_i     (wr_req),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
    .wr_ack_o     (wr_ack),
    .mem_addr_o   (mem_addr),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .underrun_o   (underrun),
`ifdef FB_CLEAR_EN
    .clr_req_i    (clr_req),
    .clr_color_i  (clr_color),
    .clr_busy_o   (clr_busy),
`endif
    .state_o      (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM: registered read, write on mem_we
  logic [2:0] ram [0:32767];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Expected framebuffer image
  logic [2:0] exp_fb [0:FB_SIZE-1];

  // Scoreboard of accepted writer requests {addr, data}
  logic [ADDR_W+2:0] exp_q[$];
  bit sb_en = 1'b0;

  int ys [10] = '{0, 1, 2, 3, 4, 5, 476, 477, 478, 479};

  function automatic int ref_addr(input int x, input int y);
    return (y / SCALE) * FB_W + (x / SCALE);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: no RAM write during a display read; writes match the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (state == 2'd1 || state == 2'd2) check("we_during_read", {31'b0, mem_we}, 32'd0);
      if (sb_en && mem_we) begin
        check("sb_write_expected", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("sb_write", {14'b0, mem_addr, mem_wdata}, {14'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int n;
    int mism;
    logic [2:0] d;

    rst_n = 1'b0; pix_x = '0; pix_y = '0; pix_active = 1'b0;
    wr_req = 1'b1; wr_addr = 15'd5; wr_data = 3'd7;
`ifdef FB_CLEAR_EN
    clr_req = 1'b0; clr_color = 3'd0;
`endif
    for (int i = 0; i < 32768; i++) ram[i] = 3'($urandom_range(0, 7));
    ram[162] = 3'd6; ram[100] = 3'd2;
    for (int i = 0; i < FB_SIZE; i++) exp_fb[i] = ram[i];

    // Reset with a pending request
    repeat (3) step();
    check("rst_pix_data", {29'b0, pix_data}, 32'd0);
    check("rst_wr_ack", {31'b0, wr_ack}, 32'd0);
    check("rst_mem_addr", {17'b0, mem_addr}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_wdata", {29'b0, mem_wdata}, 32'd0);
    check("rst_underrun", {31'b0, underrun}, 32'd0);
    check("rst_state", {30'b0, state}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (!wr_ack && n < 2) begin step(); n++; end
    check("first_ack_in_2", {31'b0, wr_ack}, 32'd1);
    check("first_ack_addr", {17'b0, mem_addr}, 32'd5);
    check("first_ack_we", {31'b0, mem_we}, 32'd1);
    wr_req = 1'b0; exp_fb[5] = 3'd7;
    step();
    check("first_ack_pulse", {31'b0, wr_ack}, 32'd0);
    check("first_we_drop", {31'b0, mem_we}, 32'd0);
    check("first_commit", {29'b0, ram[5]}, 32'd7);

    // Reset in the middle of a write abandons it
    wr_req = 1'b1; wr_addr = 15'd6; wr_data = ~exp_fb[6];
    step();
    check("midwr_we", {31'b0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midwr_async_we", {31'b0, mem_we}, 32'd0);
    check("midwr_async_ack", {31'b0, wr_ack}, 32'd0);
    wr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midwr_abandoned", {29'b0, ram[6]}, {29'b0, exp_fb[6]});

    // Display fetch of (8,4)
    pix_active = 1'b1; pix_x = 19'd8; pix_y = 19'd4;
    step();
    check("fetch_addr", {17'b0, mem_addr}, 32'(ref_addr(8, 4)));
    check("fetch_we", {31'b0, mem_we}, 32'd0);
    step(); step();
    check("fetch_data", {29'b0, pix_data}, {29'b0, exp_fb[ref_addr(8, 4)]});
    for (int x = 9; x < 12; x++) begin
      pix_x = 19'(x);
      step();
      check("no_refetch", {30'b0, state}, 32'd0);
      step();
    end

    // Write while blanked, then read it back through the display path
    pix_active = 1'b0; wr_req = 1'b1; wr_addr = 15'd100; wr_data = 3'b101;
    step();
    check("wr_ack", {31'b0, wr_ack}, 32'd1);
    check("wr_we", {31'b0, mem_we}, 32'd1);
    check("wr_addr", {17'b0, mem_addr}, 32'd100);
    check("wr_data", {29'b0, mem_wdata}, 32'd5);
    check("blank_zero", {29'b0, pix_data}, 32'd0);
    wr_req = 1'b0; exp_fb[100] = 3'b101;
    step();
    check("wr_ack_pulse", {31'b0, wr_ack}, 32'd0);
    pix_active = 1'b1; pix_x = 19'd400; pix_y = 19'd0;
    step(); step(); step();
    check("readback_100", {29'b0, pix_data}, {29'b0, exp_fb[100]});

    // Collision: display and writer request in the same cycle
    pix_active = 1'b0;
    step();
    pix_active = 1'b1; pix_x = 19'd40; pix_y = 19'd12;
    wr_req = 1'b1; wr_addr = 15'd200; wr_data = 3'd3;
    step();
    check("coll_read_first", {30'b0, state}, 32'd1);
    check("coll_read_addr", {17'b0, mem_addr}, 32'(ref_addr(40, 12)));
    n = 1;
    while (!wr_ack && n < 8) begin step(); n++; end
    check("coll_ack_edges", 32'(n), 32'd4);
    check("coll_pix", {29'b0, pix_data}, {29'b0, exp_fb[ref_addr(40, 12)]});
    wr_req = 1'b0; exp_fb[200] = 3'd3;
    step();

    // Scan-out of several lines with random background writes
    sb_en = 1'b1;
    foreach (ys[k]) begin
      for (int x = 0; x < 800; x++) begin
        for (int ph = 0; ph < 2; ph++) begin
          if (ph == 0) begin
            pix_x = 19'(x); pix_y = 19'(ys[k]);
            pix_active = (x < 640) && (ys[k] < 480);
          end
          step();
          if (wr_req && wr_ack) begin
            exp_fb[wr_addr] = wr_data;
            wr_req = 1'b0;
          end
          if (!wr_req && $urandom_range(0, 3) == 0) begin
            wr_addr = 15'($urandom_range(1600, 15999));
            wr_data = 3'($urandom_range(0, 7));
            wr_req = 1'b1;
            exp_q.push_back({wr_addr, wr_data});
          end
          if (ph == 1 && (x % 4) == 3) begin
            d = (x < 640) ? exp_fb[ref_addr(x, ys[k])] : 3'd0;
            check("scan_pix", {29'b0, pix_data}, {29'b0, d});
          end
        end
      end
    end
    pix_active = 1'b0;
    n = 0;
    while (wr_req && n < 10) begin
      step(); n++;
      if (wr_ack) begin exp_fb[wr_addr] = wr_data; wr_req = 1'b0; end
    end
    check("scan_wr_drained", {31'b0, wr_req}, 32'd0);
    step();
    sb_en = 1'b0;
    check("scan_sb_empty", 32'(exp_q.size()), 32'd0);
    check("scan_no_underrun", {31'b0, underrun}, 32'd0);
    mism = 0;
    for (int i = 0; i < FB_SIZE; i++) if (ram[i] !== exp_fb[i]) mism++;
    check("ram_image", 32'(mism), 32'd0);

    // Boundaries of the visible area
    pix_active = 1'b1; pix_x = 19'd640; pix_y = 19'd0;
    step();
    check("bound_x_nofetch", {30'b0, state}, 32'd0);
    step();
    check("bound_x_pix", {29'b0, pix_data}, 32'd0);
    pix_x = 19'd0; pix_y = 19'd480;
    step();
    check("bound_y_nofetch", {30'b0, state}, 32'd0);
    step();
    check("bound_y_pix", {29'b0, pix_data}, 32'd0);
    pix_x = 19'd639; pix_y = 19'd479;
    step();
    check("corner_addr", {17'b0, mem_addr}, 32'd19199);
    step(); step();
    check("corner_pix", {29'b0, pix_data}, {29'b0, exp_fb[19199]});

    // Display address moving while a fetch is in flight
    pix_active = 1'b0;
    step();
    pix_active = 1'b1; pix_x = 19'd0; pix_y = 19'd0;
    step();
    pix_x = 19'd4;
    step();
    check("underrun_set", {31'b0, underrun}, 32'd1);
    pix_active = 1'b0;
    step(); step(); step();
    check("underrun_sticky", {31'b0, underrun}, 32'd1);
    rst_n = 1'b0;
    step();
    check("underrun_reset", {31'b0, underrun}, 32'd0);
    rst_n = 1'b1;
    step();

`ifdef FB_CLEAR_EN
    // Framebuffer clear with a writer request pending behind it
    clr_color = 3'b010; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("clr_busy_set", {31'b0, clr_busy}, 32'd1);
    wr_req = 1'b1; wr_addr = 15'd7; wr_data = 3'd6;
    n = 0; mism = 0;
    for (int c = 0; c < 60000; c++) begin
      step();
      if (wr_ack) break;
      if (mem_we) begin
        if (mem_addr !== 15'(n) || mem_wdata !== 3'b010) mism++;
        n++;
      end
    end
    check("clr_ack_seen", {31'b0, wr_ack}, 32'd1);
    check("clr_busy_at_ack", {31'b0, clr_busy}, 32'd0);
    check("clr_write_count", 32'(n), 32'(FB_SIZE));
    check("clr_write_seq", 32'(mism), 32'd0);
    wr_req = 1'b0;
    step();
    check("clr_ram_first", {29'b0, ram[0]}, 32'd2);
    check("clr_ram_last", {29'b0, ram[FB_SIZE-1]}, 32'd2);
    check("clr_writer_after", {29'b0, ram[7]}, 32'd6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
